// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector
//   Sits after the shaping filter. Watches the signed shaped stream for pulses
//   above a threshold, captures the peak amplitude and the free-running
//   timestamp of the peak sample, flags pile-up (re-rise or timeout), and
//   presents one event per pulse on a valid/ready output register.
//
// Optional feature macro: PULSE_PEAK_BASELINE_EN
//   defined   : slow IIR baseline tracker (updates only while idle) is
//               subtracted from IN with 16-bit saturation; PEAK is corrected.
//   undefined : x = IN, no baseline logic, PEAK is the raw sample.
//
// Ports
//   clk       in   1     single clock, posedge
//   reset     in   1     synchronous, active-low
//   IN        in   16    shaped sample, two's complement
//   THR       in   16    signed threshold, compared every clock
//   READY     in   1     downstream accepts when VALID & READY
//   VALID     out  1     event present
//   PEAK      out  16    signed peak amplitude
//   TSTAMP    out  TS_W  timestamp counter value at the peak sample
//   PILEUP    out  1     re-rise seen or MAX_LEN timeout hit
//   OVERFLOW  out  1     sticky: an event was dropped while VALID was held
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for x > THR (baseline tracks here when enabled)
// RISE  | climbing; tracking max and its timestamp
// FALL  | past the peak; waiting for x <= THR or a re-rise
// HOLD  | dead time after an emit, input ignored for HOLDOFF cycles

module pulse_peak_detector #(
  parameter int HOLDOFF = 12,
  parameter int MAX_LEN = 64,
  parameter int TS_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       IN,
  input  logic [15:0]       THR,
  input  logic              READY,
  output logic              VALID,
  output logic [15:0]       PEAK,
  output logic [TS_W-1:0]   TSTAMP,
  output logic              PILEUP,
  output logic              OVERFLOW
);

  localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_FALL = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]         state, state_n;
  logic signed [15:0] x;
  logic signed [15:0] thr_s;
  logic signed [15:0] max_r, max_n;
  logic [TS_W-1:0]    ts_cnt;
  logic [TS_W-1:0]    ts_r, ts_n;
  logic               pu_r, pu_n;
  logic [LEN_W-1:0]   len_r, len_n;
  logic [HO_W-1:0]    hold_r, hold_n;
  logic               emit;
  logic               emit_pu;

  assign thr_s = THR;

`ifdef PULSE_PEAK_BASELINE_EN
  logic signed [15:0] bl;
  logic signed [16:0] diff;
  logic signed [16:0] diff_sh;

  // Difference in 17 bits; the two top bits disagree only on 16-bit overflow.
  always_comb begin
    diff    = {IN[15], IN} - {bl[15], bl};
    diff_sh = diff >>> 4;
    if (diff[16] != diff[15])
      x = diff[16] ? 16'sh8000 : 16'sh7fff;
    else
      x = diff[15:0];
  end

  // bl moves 1/16 of the way toward IN, so the sum always stays within 16 bits.
  always_ff @(posedge clk) begin
    if (!reset)
      bl <= '0;
    else if (state == S_IDLE)
      bl <= bl + diff_sh[15:0];
  end
`else
  assign x = IN;
`endif

  always_comb begin
    state_n = state;
    max_n   = max_r;
    ts_n    = ts_r;
    pu_n    = pu_r;
    len_n   = len_r;
    hold_n  = hold_r;
    emit    = 1'b0;
    emit_pu = 1'b0;
    case (state)
      S_IDLE: begin
        if (x > thr_s) begin
          state_n = S_RISE;
          max_n   = x;
          ts_n    = ts_cnt;
          len_n   = '0;
          pu_n    = 1'b0;
        end
      end
      S_RISE, S_FALL: begin
        len_n = len_r + LEN_W'(1);
        // Timeout wins over every other transition and always flags pile-up.
        if (len_r == LEN_W'(MAX_LEN - 1)) begin
          emit    = 1'b1;
          emit_pu = 1'b1;
        end else if (state == S_RISE) begin
          if (x > max_r) begin
            max_n = x;
            ts_n  = ts_cnt;
          end else if (x < max_r) begin
            state_n = S_FALL;
          end
        end else begin
          if (x <= thr_s) begin
            emit    = 1'b1;
            emit_pu = pu_r;
          end else if (x > max_r) begin
            pu_n    = 1'b1;
            max_n   = x;
            ts_n    = ts_cnt;
            state_n = S_RISE;
          end
        end
        if (emit) begin
          state_n = S_HOLD;
          hold_n  = HO_W'(HOLDOFF - 1);
        end
      end
      S_HOLD: begin
        if (hold_r == '0)
          state_n = S_IDLE;
        else
          hold_n = hold_r - HO_W'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      max_r  <= '0;
      ts_r   <= '0;
      pu_r   <= 1'b0;
      len_r  <= '0;
      hold_r <= '0;
      ts_cnt <= '0;
    end else begin
      state  <= state_n;
      max_r  <= max_n;
      ts_r   <= ts_n;
      pu_r   <= pu_n;
      len_r  <= len_n;
      hold_r <= hold_n;
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // Emit carries the registered max/ts: no emit path also updates them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      VALID    <= 1'b0;
      PEAK     <= '0;
      TSTAMP   <= '0;
      PILEUP   <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if (emit) begin
      if (!VALID || READY) begin
        VALID  <= 1'b1;
        PEAK   <= max_r;
        TSTAMP <= ts_r;
        PILEUP <= emit_pu;
      end else begin
        OVERFLOW <= 1'b1;
      end
    end else if (VALID && READY) begin
      VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Testbench for pulse_peak_detector. Each segment starts with a 3-cycle reset,
// then plays per-cycle IN/THR/READY tables. Expected outputs come from a
// sample-index scan of the whole table (pulse start, peak tracking, holdoff
// skip) followed by an output-register handshake model.
// Honours PULSE_PEAK_BASELINE_EN the same way the design does.

module tb_pulse_peak_detector;

  localparam int HOLDOFF = 12;
  localparam int MAX_LEN = 64;
  localparam int TS_W    = 32;
  localparam int NMAX    = 512;

  logic            clk;
  logic            reset;
  logic [15:0]     IN;
  logic [15:0]     THR;
  logic            READY;
  logic            VALID;
  logic [15:0]     PEAK;
  logic [TS_W-1:0] TSTAMP;
  logic            PILEUP;
  logic            OVERFLOW;

  pulse_peak_detector #(
    .HOLDOFF (HOLDOFF),
    .MAX_LEN (MAX_LEN),
    .TS_W    (TS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .IN       (IN),
    .THR      (THR),
    .READY    (READY),
    .VALID    (VALID),
    .PEAK     (PEAK),
    .TSTAMP   (TSTAMP),
    .PILEUP   (PILEUP),
    .OVERFLOW (OVERFLOW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus tables
  int s_in  [NMAX];
  int s_thr [NMAX];
  bit s_rdy [NMAX];

  // model: emits per edge, then expected outputs per edge
  bit em  [NMAX];
  int ep  [NMAX];
  int et  [NMAX];
  bit epu [NMAX];
  bit xv  [NMAX];
  int xp  [NMAX];
  int xt  [NMAX];
  bit xpl [NMAX];
  bit xov [NMAX];
  int m_bl;

  // events observed on the DUT during the last segment
  int ev_cnt;
  int ev_peak [64];
  int ev_ts   [64];
  int ev_edge [64];
  bit ev_pu   [64];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int corr(input int k);
    int d;
    d = s_in[k] - m_bl;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  task automatic compute_model(input int n);
    int k, j, mx, ts, x;
    bit pu, fall, done;
    bit v, pl, ov;
    int p, t;
    for (int i = 0; i < n; i++) em[i] = 1'b0;
    m_bl = 0;
    k = 0;
    while (k < n) begin
      x = corr(k);
`ifdef PULSE_PEAK_BASELINE_EN
      m_bl = m_bl + ((s_in[k] - m_bl) >>> 4);
`endif
      if (x > s_thr[k]) begin
        mx = x; ts = k; pu = 1'b0; fall = 1'b0; done = 1'b0;
        j = k + 1;
        while (j < n && !done) begin
          x = corr(j);
          if (j - k == MAX_LEN) begin
            done = 1'b1; pu = 1'b1;
          end else if (!fall) begin
            if (x > mx) begin mx = x; ts = j; end
            else if (x < mx) fall = 1'b1;
          end else begin
            if (x <= s_thr[j]) done = 1'b1;
            else if (x > mx) begin pu = 1'b1; mx = x; ts = j; fall = 1'b0; end
          end
          if (done) begin
            em[j] = 1'b1; ep[j] = mx; et[j] = ts; epu[j] = pu;
            k = j + HOLDOFF + 1;
          end
          j++;
        end
        if (!done) k = n;
      end else begin
        k++;
      end
    end
    v = 0; pl = 0; ov = 0; p = 0; t = 0;
    for (int i = 0; i < n; i++) begin
      if (em[i]) begin
        if (!v || s_rdy[i]) begin v = 1; p = ep[i]; t = et[i]; pl = epu[i]; end
        else ov = 1;
      end else if (v && s_rdy[i]) begin
        v = 0;
      end
      xv[i] = v; xp[i] = p; xt[i] = t; xpl[i] = pl; xov[i] = ov;
    end
  endtask

  task automatic clear_seg(input int n);
    for (int i = 0; i < n; i++) begin
      s_in[i] = 0; s_thr[i] = 100; s_rdy[i] = 1'b1;
    end
  endtask

  task automatic put_pulse(input int at);
    int shape [8];
    shape = '{0, 50, 200, 400, 300, 150, 80, 0};
    for (int i = 0; i < 8; i++) s_in[at + i] = shape[i];
  endtask

  task automatic run_seg(input int n);
    bit pv;
    @(negedge clk);
    reset = 1'b0; IN = 16'd500; THR = 16'd100; READY = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid",    VALID,          0);
    check("rst_peak",     $signed(PEAK),  0);
    check("rst_tstamp",   TSTAMP,         0);
    check("rst_pileup",   PILEUP,         0);
    check("rst_overflow", OVERFLOW,       0);
    compute_model(n);
    ev_cnt = 0;
    pv = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      IN = 16'(s_in[k]); THR = 16'(s_thr[k]); READY = s_rdy[k];
      @(negedge clk);
      check($sformatf("valid@%0d", k),    VALID,         xv[k]);
      check($sformatf("peak@%0d", k),     $signed(PEAK), xp[k]);
      check($sformatf("tstamp@%0d", k),   TSTAMP,        xt[k]);
      check($sformatf("pileup@%0d", k),   PILEUP,        xpl[k]);
      check($sformatf("overflow@%0d", k), OVERFLOW,      xov[k]);
      if (VALID && (!pv || (k > 0 && s_rdy[k-1])) && ev_cnt < 64) begin
        ev_peak[ev_cnt] = int'($signed(PEAK));
        ev_ts[ev_cnt]   = int'(TSTAMP);
        ev_pu[ev_cnt]   = PILEUP;
        ev_edge[ev_cnt] = k;
        ev_cnt++;
      end
      pv = VALID;
    end
  endtask

  initial begin
    int n, mode, thr, cur, hold_v, hold_left;
    reset = 1'b0; IN = '0; THR = 16'd100; READY = 1'b1;

    // single pulse
    clear_seg(30); put_pulse(0);
    run_seg(30);
    check("t2_count", ev_cnt, 1);
    check("t2_peak",  ev_peak[0], 400);
    check("t2_ts",    ev_ts[0], 3);
    check("t2_pu",    ev_pu[0], 0);
    check("t2_edge",  ev_edge[0], 6);

    // pile-up re-rise
    clear_seg(30);
    s_in[1] = 200; s_in[2] = 400; s_in[3] = 300; s_in[4] = 500; s_in[5] = 200; s_in[6] = 50;
    run_seg(30);
    check("t3_peak", ev_peak[0], 500);
    check("t3_ts",   ev_ts[0], 4);
    check("t3_pu",   ev_pu[0], 1);

    // backpressure: second event dropped, released at 40
    clear_seg(50); put_pulse(0); put_pulse(20);
    for (int i = 0; i < 40; i++) s_rdy[i] = 1'b0;
    run_seg(50);
    check("t4_count",    ev_cnt, 1);
    check("t4_peak",     ev_peak[0], 400);
    check("t4_ts",       ev_ts[0], 3);
    check("t4_overflow", OVERFLOW, 1);
    check("t4_valid",    VALID, 0);

    // stalled event left pending mid-holdoff; next reset must clear it
    clear_seg(12); put_pulse(0);
    for (int i = 0; i < 12; i++) s_rdy[i] = 1'b0;
    run_seg(12);
    check("t4b_valid", VALID, 1);

    // holdoff: pulse 5 after emit ignored, 13 after emit detected
    clear_seg(40); put_pulse(0);
    s_in[11] = 300; s_in[12] = 50; s_in[19] = 300;
    run_seg(40);
    check("t5_count", ev_cnt, 2);
    check("t5_ts",    ev_ts[1], 19);
    check("t5_edge",  ev_edge[1], 21);

    // timeout
    clear_seg(90);
    for (int i = 0; i <= 70; i++) s_in[i] = 1000;
    run_seg(90);
    check("t6_count", ev_cnt, 1);
    check("t6_edge",  ev_edge[0], 64);
    check("t6_peak",  ev_peak[0], 1000);
    check("t6_pu",    ev_pu[0], 1);

    // baseline plateau then pulse
    clear_seg(215);
    for (int i = 0; i < 200; i++) s_in[i] = 40;
    s_in[200] = 240;
    run_seg(215);
    check("t7_count", ev_cnt, 1);
    check("t7_ts",    ev_ts[0], 200);
`ifndef PULSE_PEAK_BASELINE_EN
    check("t7_peak",  ev_peak[0], 240);
`endif

    // randomized segments
    for (int s = 0; s < 16; s++) begin
      n = int'($urandom_range(120, 400));
      mode = int'($urandom_range(0, 2));
      thr = int'($urandom_range(0, 300)) - 100;
      cur = 0; hold_v = 0; hold_left = 0;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 49) == 0) thr = int'($urandom_range(0, 400)) - 100;
        case (mode)
          0: begin
            cur = cur - cur / 4 + int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 19) == 0) cur = cur + int'($urandom_range(100, 2000));
            if (cur > 32767) cur = 32767;
            s_in[k] = cur;
          end
          1: s_in[k] = int'($signed(16'($urandom)));
          default: begin
            if (hold_left == 0) begin
              hold_left = int'($urandom_range(1, 90));
              hold_v = int'($urandom_range(0, 1200)) - 200;
            end
            hold_left--;
            s_in[k] = hold_v;
          end
        endcase
        s_thr[k] = thr;
        s_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      run_seg(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
